// File: rtl/mem_ctrl_pkg.sv
// ============================================================================
// Module   : mem_ctrl_pkg
// Purpose  : Shared types and constants for the unified memory-port sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

  localparam logic IORD_PC  = 1'b0;
  localparam logic IORD_ALU = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mem_wait_counter.sv
// ============================================================================
// Module   : mem_wait_counter
// Purpose  : Down-counter that times the strobe window of one memory access.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wait_counter #(
  parameter int MEM_LATENCY = 2,
  localparam int CNT_W      = $clog2(MEM_LATENCY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : Arbitrates fetch vs load/store onto the single memory port and
//            sequences strobes, IorD and the IR/MDR load pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic Clock,
  input  logic Reset,
  input  logic fetch_req,
  input  logic data_req,
  input  logic data_we,
  output logic fetch_gnt,
  output logic data_gnt,
  output logic IorD,
  output logic MemRead,
  output logic MemWrite,
  output logic IRWrite,
  output logic MDRWrite,
  output logic fetch_done,
  output logic data_done,
  output logic busy
);

  localparam int CNT_W    = $clog2(MEM_LATENCY + 1);
  localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]    CNT_LOAD   = CNT_W'(MEM_LATENCY - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

  mem_state_t state_d, state_q;
  logic is_data_d, is_data_q;
  logic is_store_d, is_store_q;
  logic [STREAK_W-1:0] streak_d, streak_q;

  logic fetch_gnt_d, fetch_gnt_q;
  logic data_gnt_d, data_gnt_q;
  logic iord_d, iord_q;
  logic mem_read_d, mem_read_q;
  logic mem_write_d, mem_write_q;
  logic ir_write_d, ir_write_q;
  logic mdr_write_d, mdr_write_q;
  logic fetch_done_d, fetch_done_q;
  logic data_done_d, data_done_q;
  logic busy_d, busy_q;

  logic pick_fetch;
  logic pick_data;
  logic start;
  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;

  mem_wait_counter #(
    .MEM_LATENCY (MEM_LATENCY)
  ) u_wait_cnt (
    .clk      (Clock),
    .rst      (Reset),
    .load     (cnt_load),
    .load_val (CNT_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Data is preferred unless fetch has been passed over STARVE_LIMIT times.
  assign pick_fetch = fetch_req && (!data_req || (streak_q == STREAK_MAX));
  assign pick_data  = data_req && !pick_fetch;

  always_comb begin
    state_d    = state_q;
    is_data_d  = is_data_q;
    is_store_d = is_store_q;
    streak_d   = streak_q;
    iord_d     = iord_q;
    start      = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;

    case (state_q)
      IDLE: begin
        if (fetch_req || data_req) begin
          state_d    = ACCESS;
          start      = 1'b1;
          cnt_load   = 1'b1;
          is_data_d  = pick_data;
          is_store_d = pick_data && data_we;
          iord_d     = pick_data ? IORD_ALU : IORD_PC;
          if (pick_fetch) begin
            streak_d = '0;
          end else if (fetch_req && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 1'b1;
          end
        end
      end
      ACCESS: begin
        if (cnt_zero) begin
          state_d = DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the next state.
    fetch_gnt_d  = start && !is_data_d;
    data_gnt_d   = start && is_data_d;
    mem_read_d   = (state_d == ACCESS) && !is_store_d;
    mem_write_d  = (state_d == ACCESS) && is_store_d;
    ir_write_d   = (state_d == DONE) && !is_data_d;
    mdr_write_d  = (state_d == DONE) && is_data_d && !is_store_d;
    fetch_done_d = (state_d == DONE) && !is_data_d;
    data_done_d  = (state_d == DONE) && is_data_d;
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      is_data_q    <= 1'b0;
      is_store_q   <= 1'b0;
      streak_q     <= '0;
      fetch_gnt_q  <= 1'b0;
      data_gnt_q   <= 1'b0;
      iord_q       <= IORD_PC;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      ir_write_q   <= 1'b0;
      mdr_write_q  <= 1'b0;
      fetch_done_q <= 1'b0;
      data_done_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_data_q    <= is_data_d;
      is_store_q   <= is_store_d;
      streak_q     <= streak_d;
      fetch_gnt_q  <= fetch_gnt_d;
      data_gnt_q   <= data_gnt_d;
      iord_q       <= iord_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      ir_write_q   <= ir_write_d;
      mdr_write_q  <= mdr_write_d;
      fetch_done_q <= fetch_done_d;
      data_done_q  <= data_done_d;
      busy_q       <= busy_d;
    end
  end

  assign fetch_gnt  = fetch_gnt_q;
  assign data_gnt   = data_gnt_q;
  assign IorD       = iord_q;
  assign MemRead    = mem_read_q;
  assign MemWrite   = mem_write_q;
  assign IRWrite    = ir_write_q;
  assign MDRWrite   = mdr_write_q;
  assign fetch_done = fetch_done_q;
  assign data_done  = data_done_q;
  assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// Module   : tb_mem_access_ctrl
// Purpose  : Self-checking bench for mem_access_ctrl (latency 2 and latency 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;

  localparam int LIMIT = 2;

  // Output vector bit positions: {fg,dg,iord,mr,mw,ir,mdr,fd,dd,busy}
  localparam logic [9:0] FG   = 10'b10_0000_0000;
  localparam logic [9:0] DG   = 10'b01_0000_0000;
  localparam logic [9:0] IO   = 10'b00_1000_0000;
  localparam logic [9:0] MR   = 10'b00_0100_0000;
  localparam logic [9:0] MW   = 10'b00_0010_0000;
  localparam logic [9:0] IR   = 10'b00_0001_0000;
  localparam logic [9:0] MDR  = 10'b00_0000_1000;
  localparam logic [9:0] FD   = 10'b00_0000_0100;
  localparam logic [9:0] DD   = 10'b00_0000_0010;
  localparam logic [9:0] BZ   = 10'b00_0000_0001;
  localparam logic [9:0] ALL  = 10'h3FF;
  localparam logic [9:0] NIO  = 10'h37F;

  logic Clock = 1'b0;
  logic Reset;
  logic fetch_req, data_req, data_we;
  logic fetch_gnt, data_gnt, IorD, MemRead, MemWrite;
  logic IRWrite, MDRWrite, fetch_done, data_done, busy;
  logic f1_req;
  logic f1_gnt, d1_gnt, iord1, mr1, mw1, ir1, mdr1, fd1, dd1, busy1;
  logic [9:0] obs, obs1;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  mem_access_ctrl #(.MEM_LATENCY(2), .STARVE_LIMIT(LIMIT)) u_dut (
    .Clock(Clock), .Reset(Reset),
    .fetch_req(fetch_req), .data_req(data_req), .data_we(data_we),
    .fetch_gnt(fetch_gnt), .data_gnt(data_gnt), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MDRWrite(MDRWrite), .fetch_done(fetch_done), .data_done(data_done),
    .busy(busy)
  );

  mem_access_ctrl #(.MEM_LATENCY(1), .STARVE_LIMIT(LIMIT)) u_dut1 (
    .Clock(Clock), .Reset(Reset),
    .fetch_req(f1_req), .data_req(1'b0), .data_we(1'b0),
    .fetch_gnt(f1_gnt), .data_gnt(d1_gnt), .IorD(iord1),
    .MemRead(mr1), .MemWrite(mw1), .IRWrite(ir1),
    .MDRWrite(mdr1), .fetch_done(fd1), .data_done(dd1),
    .busy(busy1)
  );

  assign obs  = {fetch_gnt, data_gnt, IorD, MemRead, MemWrite,
                 IRWrite, MDRWrite, fetch_done, data_done, busy};
  assign obs1 = {f1_gnt, d1_gnt, iord1, mr1, mw1, ir1, mdr1, fd1, dd1, busy1};

  task automatic chk(input string name, input logic [9:0] act,
                     input logic [9:0] exp, input logic [9:0] care);
    n_checks++;
    if ((act & care) !== (exp & care)) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %b expected %b (care %b)",
               name, cyc, act, exp, care);
    end
  endtask

  typedef struct {
    logic       f;
    logic       d;
    logic       we;
    logic [9:0] exp;
    logic [9:0] care;
  } vec_t;

  vec_t vt[15];
  logic exp_q[$];   // 1 = data grant expected, 0 = fetch grant expected

  initial begin
    int streak;
    int last_gnt;
    int waited;
    logic got_data, exp_data;

    // fetch alone
    vt[0]  = '{1'b1, 1'b0, 1'b0, 10'd0,        ALL};
    vt[1]  = '{1'b1, 1'b0, 1'b0, FG|MR|BZ,     ALL};
    vt[2]  = '{1'b0, 1'b0, 1'b0, MR|BZ,        ALL};
    vt[3]  = '{1'b0, 1'b0, 1'b0, IR|FD|BZ,     ALL};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 10'd0,        NIO};
    // load
    vt[5]  = '{1'b0, 1'b1, 1'b0, 10'd0,        NIO};
    vt[6]  = '{1'b0, 1'b1, 1'b0, DG|IO|MR|BZ,  ALL};
    vt[7]  = '{1'b0, 1'b0, 1'b0, IO|MR|BZ,     ALL};
    vt[8]  = '{1'b0, 1'b0, 1'b0, IO|MDR|DD|BZ, ALL};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 10'd0,        NIO};
    // store, data_we drops mid-access
    vt[10] = '{1'b0, 1'b1, 1'b1, 10'd0,        NIO};
    vt[11] = '{1'b0, 1'b1, 1'b1, DG|IO|MW|BZ,  ALL};
    vt[12] = '{1'b0, 1'b0, 1'b0, IO|MW|BZ,     ALL};
    vt[13] = '{1'b0, 1'b0, 1'b0, IO|DD|BZ,     ALL};
    vt[14] = '{1'b0, 1'b0, 1'b0, 10'd0,        NIO};

    Reset = 1'b1; fetch_req = 1'b0; data_req = 1'b0; data_we = 1'b0; f1_req = 1'b0;
    #1;
    chk("reset_state", obs, 10'd0, ALL);
    chk("reset_state_l1", obs1, 10'd0, ALL);
    repeat (2) @(negedge Clock);
    Reset = 1'b0;

    foreach (vt[i]) begin
      @(posedge Clock); #1;
      fetch_req = vt[i].f; data_req = vt[i].d; data_we = vt[i].we;
      @(negedge Clock);
      chk($sformatf("vec%0d", i), obs, vt[i].exp, vt[i].care);
    end

    // Both requesters held: expected order from a starvation-counter model.
    @(posedge Clock); #1;
    fetch_req = 1'b1; data_req = 1'b1; data_we = 1'b0;
    streak = 0;
    for (int k = 0; k < 6; k++) begin
      if (streak == LIMIT) begin exp_q.push_back(1'b0); streak = 0; end
      else begin exp_q.push_back(1'b1); streak++; end
    end
    last_gnt = -1;
    for (int k = 0; k < 6; k++) begin
      waited = 0;
      do begin
        @(negedge Clock);
        waited++;
      end while (!(fetch_gnt || data_gnt) && waited < 10);
      if (!(fetch_gnt || data_gnt)) begin
        n_checks++; n_errors++;
        $display("FAIL arb_timeout grant %0d: no grant within 10 cycles", k);
      end else begin
        got_data = data_gnt;
        exp_data = exp_q.pop_front();
        chk($sformatf("arb_order%0d", k), {9'd0, got_data}, {9'd0, exp_data}, 10'd1);
        if (last_gnt >= 0) begin
          n_checks++;
          if (cyc - last_gnt != 4) begin
            n_errors++;
            $display("FAIL arb_gap%0d: got %0d cycles expected 4", k, cyc - last_gnt);
          end
        end
        last_gnt = cyc;
      end
    end
    @(posedge Clock); #1;
    fetch_req = 1'b0; data_req = 1'b0;
    repeat (5) @(negedge Clock);
    chk("arb_drain_idle", obs, 10'd0, NIO);

    // Reset during second cycle of a fetch access
    @(posedge Clock); #1; fetch_req = 1'b1;
    @(posedge Clock); #1; fetch_req = 1'b0;
    @(negedge Clock);
    chk("rst_pre_gnt", obs, FG|MR|BZ, ALL);
    @(posedge Clock); #1; Reset = 1'b1;
    #1;
    chk("rst_async", obs, 10'd0, ALL);
    @(negedge Clock); #2; Reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clock);
      chk($sformatf("rst_after%0d", k), obs, 10'd0, ALL);
    end

    // Fetch pulsed while busy, withdrawn before IDLE: never granted
    @(posedge Clock); #1; data_req = 1'b1; data_we = 1'b0;
    @(posedge Clock); #1; data_req = 1'b0;
    @(posedge Clock); #1; fetch_req = 1'b1;
    @(posedge Clock); #1; fetch_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge Clock);
      chk($sformatf("withdrawn%0d", k), obs, 10'd0, FG);
    end
    chk("withdrawn_idle", obs, 10'd0, BZ);

    // Latency-1 instance: done two cycles after request
    @(posedge Clock); #1; f1_req = 1'b1;
    @(negedge Clock); chk("l1_c0", obs1, 10'd0, ALL);
    @(posedge Clock); #1; f1_req = 1'b0;
    @(negedge Clock); chk("l1_c1", obs1, FG|MR|BZ, ALL);
    @(negedge Clock); chk("l1_c2", obs1, IR|FD|BZ, ALL);
    @(negedge Clock); chk("l1_c3", obs1, 10'd0, ALL);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
